// File: rtl/eth_rx.sv
// eth_rx: RMII receive path with preamble hunt, header capture, FCS strip and CRC check.
// Define ETH_RX_ADDR_FILTER_EN to drop frames not sent to pMAC_ADDR or broadcast.
module eth_rx #(
    parameter logic [47:0] pMAC_ADDR  = 48'h020000000001,
    parameter int          pMAX_FRAME = 1518
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [1:0]  Rxd,
    input  logic        Crs_Dv,
    output logic [7:0]  Eth_Byte,
    output logic        Eth_Byte_Valid,
    output logic        Eth_Pkt_Start,
    output logic        Eth_Pkt_Done,
    output logic        Eth_Crc_Ok,
    output logic        Eth_Frame_Err,
    output logic [47:0] Eth_Src_Addr,
    output logic [15:0] Eth_Len_Type
);

    localparam int lCntW = $clog2(pMAX_FRAME + 2);
    localparam logic [31:0] lCrcInit = 32'hFFFFFFFF;
    localparam logic [31:0] lCrcRes = 32'hDEBB20E3;
    localparam logic [lCntW-1:0] lMaxCnt = lCntW'(pMAX_FRAME);
    localparam logic [lCntW-1:0] lMinCnt = lCntW'(64);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        PREAMBLE,
        HEADER,
        DATA,
        DROP,
        DONE
    } state_t;

    state_t state;
    logic [1:0] dibitCnt;
    logic [2:0] preCnt;
    logic [7:0] shiftByte;
    logic [lCntW-1:0] byteCnt;
    logic [31:0] crc;
    logic [39:0] hdrShift;
    logic [3:0][7:0] dly;
    logic [2:0] dlyCnt;
    logic started;
    logic reject;

    logic dibitValid;
    logic preamble;
    logic [7:0] nextByte;
    logic [47:0] hdrNext;
    logic [31:0] crcNext;
    logic [2:0] preInc;

    function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Carrier low mid-byte is still data: RMII toggles CRS_DV near frame end.
    always_comb begin
        dibitValid = Crs_Dv || (dibitCnt != 2'd0);
        preamble = Crs_Dv && (Rxd == 2'b01);
        nextByte = {Rxd, shiftByte[7:2]};
        hdrNext = {hdrShift, nextByte};
        crcNext = crcByte(crc, nextByte);
        preInc = (preCnt == 3'd4) ? preCnt : preCnt + 3'd1;
    end

`ifndef ETH_RX_ADDR_FILTER_EN
    logic unusedMac;
    assign unusedMac = ^pMAC_ADDR;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= WAIT_IDLE;
            dibitCnt <= '0;
            preCnt <= '0;
            shiftByte <= '0;
            byteCnt <= '0;
            crc <= lCrcInit;
            hdrShift <= '0;
            dly <= '0;
            dlyCnt <= '0;
            started <= 1'b0;
            reject <= 1'b0;
            Eth_Byte <= '0;
            Eth_Byte_Valid <= 1'b0;
            Eth_Pkt_Start <= 1'b0;
            Eth_Pkt_Done <= 1'b0;
            Eth_Crc_Ok <= 1'b0;
            Eth_Frame_Err <= 1'b0;
            Eth_Src_Addr <= '0;
            Eth_Len_Type <= '0;
        end else begin
            Eth_Byte_Valid <= 1'b0;
            Eth_Pkt_Start <= 1'b0;
            Eth_Pkt_Done <= 1'b0;
            Eth_Crc_Ok <= 1'b0;
            Eth_Frame_Err <= 1'b0;
            unique case (state)
                WAIT_IDLE: begin
                    if (!Crs_Dv) state <= IDLE;
                end
                IDLE: begin
                    if (preamble) begin
                        state <= PREAMBLE;
                        preCnt <= preInc;
                        reject <= 1'b0;
                    end else if (!Crs_Dv) begin
                        preCnt <= '0;
                    end
                end
                PREAMBLE: begin
                    if (!Crs_Dv) begin
                        state <= IDLE;
                        preCnt <= '0;
                    end else begin
                        unique case (Rxd)
                            2'b01: preCnt <= preInc;
                            2'b00: preCnt <= preCnt;
                            2'b11: begin
                                preCnt <= '0;
                                if (preCnt >= 3'd4) begin
                                    state <= HEADER;
                                    dibitCnt <= '0;
                                    byteCnt <= '0;
                                    crc <= lCrcInit;
                                    dlyCnt <= '0;
                                    started <= 1'b0;
                                end else begin
                                    state <= DROP;
                                end
                            end
                            default: begin
                                preCnt <= '0;
                                state <= DROP;
                            end
                        endcase
                    end
                end
                HEADER, DATA: begin
                    if (!dibitValid) begin
                        state <= DONE;
                        Eth_Pkt_Done <= !reject;
                        Eth_Crc_Ok <= !reject && (crc == lCrcRes);
                        Eth_Frame_Err <= !reject && (byteCnt < lMinCnt);
                    end else begin
                        shiftByte <= nextByte;
                        dibitCnt <= dibitCnt + 2'd1;
                        if (dibitCnt == 2'd3) begin
                            if (byteCnt == lMaxCnt) begin
                                state <= DROP;
                            end else begin
                                byteCnt <= byteCnt + 1'b1;
                                crc <= crcNext;
                                hdrShift <= hdrNext[39:0];
                                if (state == HEADER) begin
`ifdef ETH_RX_ADDR_FILTER_EN
                                    if (byteCnt == lCntW'(5) && hdrNext != '1 &&
                                        hdrNext != pMAC_ADDR)
                                        reject <= 1'b1;
`endif
                                    if (byteCnt == lCntW'(11) && !reject)
                                        Eth_Src_Addr <= hdrNext;
                                    if (byteCnt == lCntW'(13)) begin
                                        if (!reject) Eth_Len_Type <= hdrNext[15:0];
                                        state <= DATA;
                                    end
                                end else begin
                                    // Four-byte delay line holds back the FCS.
                                    dly <= {dly[2:0], nextByte};
                                    if (dlyCnt == 3'd4) begin
                                        if (!reject) begin
                                            Eth_Byte <= dly[3];
                                            Eth_Byte_Valid <= 1'b1;
                                            Eth_Pkt_Start <= !started;
                                        end
                                        started <= 1'b1;
                                    end else begin
                                        dlyCnt <= dlyCnt + 3'd1;
                                    end
                                end
                            end
                        end
                    end
                end
                DROP: begin
                    if (!Crs_Dv) begin
                        state <= DONE;
                        Eth_Pkt_Done <= !reject;
                        Eth_Frame_Err <= !reject;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    preCnt <= preamble ? 3'd1 : 3'd0;
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx.sv
// tb_eth_rx: random and directed RMII frames checked against a byte-level frame model.
// Expected payload, CRC status and framing status come from the frame contents.
module tb_eth_rx;

    localparam logic [47:0] MAC = 48'h020000000001;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
    localparam int MAX = 1518;
`ifdef ETH_RX_ADDR_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic [1:0] Rxd = 2'b00;
    logic Crs_Dv = 1'b0;
    logic [7:0] Eth_Byte;
    logic Eth_Byte_Valid;
    logic Eth_Pkt_Start;
    logic Eth_Pkt_Done;
    logic Eth_Crc_Ok;
    logic Eth_Frame_Err;
    logic [47:0] Eth_Src_Addr;
    logic [15:0] Eth_Len_Type;

    always #10 Clk = ~Clk;

    eth_rx #(.pMAC_ADDR(MAC), .pMAX_FRAME(MAX)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Rxd(Rxd),
        .Crs_Dv(Crs_Dv),
        .Eth_Byte(Eth_Byte),
        .Eth_Byte_Valid(Eth_Byte_Valid),
        .Eth_Pkt_Start(Eth_Pkt_Start),
        .Eth_Pkt_Done(Eth_Pkt_Done),
        .Eth_Crc_Ok(Eth_Crc_Ok),
        .Eth_Frame_Err(Eth_Frame_Err),
        .Eth_Src_Addr(Eth_Src_Addr),
        .Eth_Len_Type(Eth_Len_Type)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] frame[$];
    logic [7:0] rxQ[$];
    int startCnt = 0;
    int doneCnt = 0;
    int spaceErr = 0;
    int stray = 0;
    int cyc = 0;
    int lastV = -100;
    logic [7:0] startByte = '0;
    logic gotCrc = 1'b0;
    logic gotErr = 1'b0;
    logic [47:0] expSrc = '0;
    logic [15:0] expType = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        cyc++;
        if (Eth_Byte_Valid) begin
            rxQ.push_back(Eth_Byte);
            if (cyc - lastV < 4) spaceErr++;
            lastV = cyc;
        end
        if (Eth_Pkt_Start) begin
            startCnt++;
            startByte = Eth_Byte;
            if (!Eth_Byte_Valid) spaceErr++;
        end
        if (Eth_Pkt_Done) begin
            doneCnt++;
            gotCrc = Eth_Crc_Ok;
            gotErr = Eth_Frame_Err;
            if (Eth_Byte_Valid) stray++;
        end else if (Eth_Crc_Ok || Eth_Frame_Err) begin
            stray++;
        end
    end

    function automatic logic [31:0] fcsOf(input int len);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < len; i++)
            for (int b = 0; b < 8; b++)
                c = (c[0] ^ frame[i][b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return ~c;
    endfunction

    function automatic bit fcsOk(input int n);
        return {frame[n-1], frame[n-2], frame[n-3], frame[n-4]} == fcsOf(n - 4);
    endfunction

    task automatic build(input logic [47:0] dst, input logic [47:0] src,
                         input logic [15:0] typ, input int plen, input bit seq);
        logic [31:0] c;
        frame.delete();
        for (int i = 0; i < 6; i++) frame.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frame.push_back(src[47-8*i -: 8]);
        frame.push_back(typ[15:8]);
        frame.push_back(typ[7:0]);
        for (int i = 0; i < plen; i++)
            frame.push_back(seq ? 8'(i) : 8'($urandom));
        c = fcsOf(frame.size());
        for (int k = 0; k < 4; k++) frame.push_back(c[8*k +: 8]);
    endtask

    task automatic sendDibit(input logic [1:0] d, input logic dv);
        @(negedge Clk);
        Rxd = d;
        Crs_Dv = dv;
    endtask

    task automatic sendFrame(input int nPre, input int toggleN, input int rstAt);
        int n;
        n = frame.size();
        for (int i = 0; i < nPre; i++) sendDibit(2'b01, 1'b1);
        sendDibit(2'b11, 1'b1);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                logic dv;
                logic [7:0] b;
                dv = 1'b1;
                b = frame[i];
                if (i >= n - toggleN && k >= 2) dv = 1'($urandom_range(0, 1));
                sendDibit(b[2*k +: 2], dv);
                if (i == rstAt && k == 0) begin
                    Rst = 1'b1;
                    @(negedge Clk);
                    Rst = 1'b0;
                    check("midrst_out", {Eth_Byte_Valid, Eth_Pkt_Start, Eth_Pkt_Done,
                          Eth_Crc_Ok, Eth_Frame_Err, Eth_Byte}, 64'd0);
                    check("midrst_hdr", {Eth_Src_Addr, Eth_Len_Type}, 64'd0);
                    rxQ.delete();
                    startCnt = 0;
                    doneCnt = 0;
                end
            end
        end
        for (int i = 0; i < 40; i++) sendDibit(2'b00, 1'b0);
    endtask

    task automatic runFrame(input string nm, input int nPre, input int toggleN, input int rstAt);
        int n;
        int expN;
        int bad;
        bit expDone;
        bit expCrc;
        bit expErr;
        bit deliver;
        logic [47:0] dst;
        n = frame.size();
        dst = {frame[0], frame[1], frame[2], frame[3], frame[4], frame[5]};
        deliver = !FILTER_ON || dst == BCAST || dst == MAC;
        expN = 0;
        expDone = 1'b0;
        expCrc = 1'b0;
        expErr = 1'b0;
        if (rstAt >= 0) begin
            expSrc = '0;
            expType = '0;
        end else if (nPre < 4) begin
            expDone = 1'b1;
            expErr = 1'b1;
        end else if (deliver) begin
            expN = (n > MAX) ? MAX - 18 : n - 18;
            expDone = 1'b1;
            expCrc = (n <= MAX) && fcsOk(n);
            expErr = (n < 64) || (n > MAX);
            expSrc = {frame[6], frame[7], frame[8], frame[9], frame[10], frame[11]};
            expType = {frame[12], frame[13]};
        end
        rxQ.delete();
        startCnt = 0;
        doneCnt = 0;
        sendFrame(nPre, toggleN, rstAt);
        check({nm, "_strobes"}, rxQ.size(), expN);
        bad = 0;
        for (int j = 0; j < rxQ.size() && j < expN; j++)
            if (rxQ[j] !== frame[14+j]) bad++;
        check({nm, "_payload"}, bad, 0);
        check({nm, "_start"}, startCnt, (expN > 0) ? 1 : 0);
        if (expN > 0) check({nm, "_startbyte"}, startByte, frame[14]);
        check({nm, "_done"}, doneCnt, expDone);
        if (expDone && doneCnt > 0) begin
            check({nm, "_crcok"}, gotCrc, expCrc);
            check({nm, "_ferr"}, gotErr, expErr);
        end
        check({nm, "_src"}, Eth_Src_Addr, expSrc);
        check({nm, "_type"}, Eth_Len_Type, expType);
    endtask

    initial begin
        Rst = 1'b1;
        repeat (4) @(negedge Clk);
        check("reset_out", {Eth_Byte_Valid, Eth_Pkt_Start, Eth_Pkt_Done,
              Eth_Crc_Ok, Eth_Frame_Err, Eth_Byte}, 64'd0);
        check("reset_hdr", {Eth_Src_Addr, Eth_Len_Type}, 64'd0);
        Rst = 1'b0;
        repeat (4) @(negedge Clk);

        build(BCAST, MAC, 16'h0800, 46, 1'b1);
        runFrame("bcast", 31, 0, -1);

        build(BCAST, MAC, 16'h0800, 46, 1'b1);
        frame[24] = frame[24] ^ 8'h08;
        runFrame("flip", 31, 0, -1);

        build(BCAST, 48'h0A0B0C0D0E0F, 16'h0806, 22, 1'b1);
        runFrame("runt40", 31, 0, -1);

        build(MAC, 48'h021122334455, 16'h88B5, 50, 1'b0);
        runFrame("toggle", 31, 8, -1);

        build(BCAST, MAC, 16'h0800, 46, 1'b1);
        runFrame("rst", 31, 0, 34);

        build(BCAST, MAC, 16'h0800, 46, 1'b1);
        runFrame("clean", 31, 0, -1);

        build(BCAST, 48'h026666666666, 16'h0800, 46, 1'b0);
        runFrame("pre3", 3, 0, -1);

        build(BCAST, 48'h027777777777, 16'h86DD, 46, 1'b0);
        runFrame("pre4", 4, 0, -1);

        build(48'h020000000002, 48'h028888888888, 16'h0800, 46, 1'b0);
        runFrame("other", 31, 0, -1);

        build(MAC, 48'h029999999999, 16'h0800, 46, 1'b0);
        runFrame("mine", 31, 0, -1);

        build(BCAST, 48'h02ABCDEF0123, 16'h0800, 1512, 1'b0);
        runFrame("oversize", 31, 0, -1);

        for (int r = 0; r < 8; r++) begin
            logic [47:0] dst;
            int sel;
            sel = $urandom_range(0, 2);
            dst = (sel == 0) ? BCAST : (sel == 1) ? MAC : {32'h02000000, 16'($urandom)};
            build(dst, {16'h0200, 32'($urandom)}, 16'($urandom),
                  $urandom_range(12, 110), 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                int idx;
                idx = $urandom_range(0, frame.size() - 1);
                frame[idx] = frame[idx] ^ (8'h01 << $urandom_range(0, 7));
            end
            runFrame("rand", $urandom_range(4, 31),
                     ($urandom_range(0, 1) == 1) ? 6 : 0, -1);
        end

        check("spacing", spaceErr, 0);
        check("stray_status", stray, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
